// File: rtl/gf2_pkg.sv
// Shared definitions for the gf2 family of masking blocks (splitter_gf2,
// adder_gf2 and friends).
//
// Contents:
//   LFSR_TAPS          feedback polynomial of the 32-bit Galois LFSR
//   LFSR_DEFAULT_SEED  substitute seed used when a block is given seed 0
//   lfsr_state_t       32-bit LFSR state type
//   lfsr_next()        one right-shift step of the Galois LFSR
package gf2_pkg;

    typedef logic [31:0] lfsr_state_t;

    localparam lfsr_state_t LFSR_TAPS         = 32'h8020_0003;
    localparam lfsr_state_t LFSR_DEFAULT_SEED = 32'h0000_0001;

    // Galois form: the bit shifted out of the bottom decides whether the
    // tap pattern is folded back into the shifted state.
    function automatic lfsr_state_t lfsr_next(input lfsr_state_t s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/lfsr_gf2.sv
// 32-bit Galois LFSR that steps only when asked to.
//
// Parameters:
//   SEED       reset state; 0 would lock the register up, so it is
//              replaced by LFSR_DEFAULT_SEED
// Ports:
//   i_clock    clock
//   i_reset    synchronous active-high reset, reloads the seed
//   i_advance  step the LFSR by one on this clock edge
//   o_state    current (pre-advance) state
module lfsr_gf2
    import gf2_pkg::*;
#(
    parameter logic [31:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_advance,
    output lfsr_state_t o_state
);

    localparam lfsr_state_t RESET_STATE = (SEED == 32'h0000_0000) ? LFSR_DEFAULT_SEED : SEED;

    lfsr_state_t state_q;
    lfsr_state_t state_d;

    always_comb begin
        state_d = state_q;
        if (i_advance) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: rtl/splitter_gf2.sv
// Splits one valid/ready stream into two GF(2) additive shares:
//   lhs = pseudo-random mask, rhs = data ^ mask, so lhs ^ rhs == data.
// Each share leaves through its own registered valid/ready stream and is
// drained independently; a new word is taken only when both output
// slots are free (or freeing this cycle).
//
// Build option:
//   SPLITTER_GF2_ZERO_MASK_EN  when defined the LFSR is dropped and the
//                              mask is 0 (lhs = 0, rhs = data), for
//                              plain-data bring-up.
// Parameters:
//   WIDTH  data width (1..32)
//   SEED   LFSR reset state (0 is replaced by LFSR_DEFAULT_SEED)
// Ports:
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_data, i_valid, o_ready    input stream
//   o_lhs_data/valid, i_lhs_ready  mask share stream
//   o_rhs_data/valid, i_rhs_ready  masked-data share stream
module splitter_gf2
    import gf2_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_lhs_data,
    output logic             o_lhs_valid,
    input  logic             i_lhs_ready,
    output logic [WIDTH-1:0] o_rhs_data,
    output logic             o_rhs_valid,
    input  logic             i_rhs_ready
);

    logic             lhs_valid_q, lhs_valid_d;
    logic             rhs_valid_q, rhs_valid_d;
    logic [WIDTH-1:0] lhs_data_q, lhs_data_d;
    logic [WIDTH-1:0] rhs_data_q, rhs_data_d;
    logic [WIDTH-1:0] mask;
    logic             lhs_free;
    logic             rhs_free;
    logic             accept;

`ifdef SPLITTER_GF2_ZERO_MASK_EN
    assign mask = '0;
`else
    lfsr_state_t lfsr_state;
    logic        lfsr_unused;

    lfsr_gf2 #(
        .SEED(SEED)
    ) u_lfsr (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_advance(accept),
        .o_state  (lfsr_state)
    );

    assign mask        = lfsr_state[WIDTH-1:0];
    assign lfsr_unused = ^lfsr_state;
`endif

    // Valids and ready are masked during reset so that no handshake on
    // either side can complete in the reset cycle.
    assign o_lhs_valid = lhs_valid_q & ~i_reset;
    assign o_rhs_valid = rhs_valid_q & ~i_reset;
    assign lhs_free    = ~o_lhs_valid | i_lhs_ready;
    assign rhs_free    = ~o_rhs_valid | i_rhs_ready;
    assign o_ready     = lhs_free & rhs_free & ~i_reset;
    assign accept      = i_valid & o_ready;

    assign o_lhs_data  = lhs_data_q;
    assign o_rhs_data  = rhs_data_q;

    // A new accept reloads both slots and wins over a same-cycle drain;
    // otherwise each slot empties on its own handshake and the data
    // registers simply hold.
    always_comb begin
        lhs_valid_d = lhs_valid_q;
        rhs_valid_d = rhs_valid_q;
        lhs_data_d  = lhs_data_q;
        rhs_data_d  = rhs_data_q;
        if (accept) begin
            lhs_valid_d = 1'b1;
            rhs_valid_d = 1'b1;
            lhs_data_d  = mask;
            rhs_data_d  = i_data ^ mask;
        end else begin
            if (lhs_valid_q && i_lhs_ready) begin
                lhs_valid_d = 1'b0;
            end
            if (rhs_valid_q && i_rhs_ready) begin
                rhs_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            lhs_valid_q <= 1'b0;
            rhs_valid_q <= 1'b0;
            lhs_data_q  <= '0;
            rhs_data_q  <= '0;
        end else begin
            lhs_valid_q <= lhs_valid_d;
            rhs_valid_q <= rhs_valid_d;
            lhs_data_q  <= lhs_data_d;
            rhs_data_q  <= rhs_data_d;
        end
    end

endmodule

// File: tb/tb_splitter_gf2.sv
// Self-checking bench for splitter_gf2 (WIDTH=16, SEED=1).
// A transaction-level scoreboard predicts, for every cycle, which shares
// are pending on each side, what o_ready must be, and which share value
// each output must show; the mask sequence comes from a reference LFSR
// stepped once per accepted word. Directed phases cover idle, the
// streaming example, skewed backpressure, a randomized round trip and
// reset mid-stream. Build with SPLITTER_GF2_ZERO_MASK_EN to expect a
// zero mask.
module tb_splitter_gf2;

`ifdef SPLITTER_GF2_ZERO_MASK_EN
    localparam bit ZM = 1'b1;
`else
    localparam bit ZM = 1'b0;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_lhs_data;
    logic        o_lhs_valid;
    logic        i_lhs_ready;
    logic [15:0] o_rhs_data;
    logic        o_rhs_valid;
    logic        i_rhs_ready;

    splitter_gf2 #(
        .WIDTH(16),
        .SEED (32'h0000_0001)
    ) dut (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_lhs_data (o_lhs_data),
        .o_lhs_valid(o_lhs_valid),
        .i_lhs_ready(i_lhs_ready),
        .o_rhs_data (o_rhs_data),
        .o_rhs_valid(o_rhs_valid),
        .i_rhs_ready(i_rhs_ready)
    );

    always #5 i_clock = ~i_clock;

    int errors = 0;
    int checks = 0;

    // Scoreboard state
    logic [31:0] ref_state;
    logic [15:0] lhs_q[$];
    logic [15:0] rhs_q[$];
    logic [15:0] lhs_last;
    logic [15:0] rhs_last;
    logic [15:0] lhs_log[$];
    logic [15:0] rhs_log[$];
    logic [15:0] in_log[$];
    bit          last_accept;

    function automatic logic [15:0] ref_mask();
        return ZM ? 16'h0000 : ref_state[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares every DUT output against the scoreboard for this cycle.
    task automatic checkOutput(input bit rst, input bit lr, input bit rr);
        bit exp_lv;
        bit exp_rv;
        bit exp_rdy;
        exp_lv  = !rst && lhs_q.size() != 0;
        exp_rv  = !rst && rhs_q.size() != 0;
        exp_rdy = !rst && (lhs_q.size() == 0 || lr) && (rhs_q.size() == 0 || rr);
        check("o_ready", {31'd0, o_ready}, {31'd0, exp_rdy});
        check("o_lhs_valid", {31'd0, o_lhs_valid}, {31'd0, exp_lv});
        check("o_rhs_valid", {31'd0, o_rhs_valid}, {31'd0, exp_rv});
        check("o_lhs_data", {16'd0, o_lhs_data}, {16'd0, lhs_last});
        check("o_rhs_data", {16'd0, o_rhs_data}, {16'd0, rhs_last});
    endtask

    // Drives one cycle of inputs, checks outputs, advances the
    // scoreboard, then steps to just after the next rising edge.
    task automatic applyStimulus(input bit rst, input bit v, input logic [15:0] d,
                                 input bit lr, input bit rr);
        bit exp_rdy;
        i_reset     = rst;
        i_valid     = v;
        i_data      = d;
        i_lhs_ready = lr;
        i_rhs_ready = rr;
        #1;
        checkOutput(rst, lr, rr);
        exp_rdy     = !rst && (lhs_q.size() == 0 || lr) && (rhs_q.size() == 0 || rr);
        last_accept = v && exp_rdy;
        if (rst) begin
            lhs_q.delete();
            rhs_q.delete();
            ref_state = 32'h0000_0001;
            lhs_last  = 16'h0000;
            rhs_last  = 16'h0000;
        end else begin
            if (lhs_q.size() != 0 && lr) begin
                void'(lhs_q.pop_front());
                lhs_log.push_back(o_lhs_data);
            end
            if (rhs_q.size() != 0 && rr) begin
                void'(rhs_q.pop_front());
                rhs_log.push_back(o_rhs_data);
            end
            if (last_accept) begin
                lhs_last = ref_mask();
                rhs_last = d ^ ref_mask();
                lhs_q.push_back(lhs_last);
                rhs_q.push_back(rhs_last);
                in_log.push_back(d);
                ref_state = {1'b0, ref_state[31:1]} ^ (ref_state[0] ? 32'h8020_0003 : 32'h0);
            end
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic clearLogs();
        lhs_log.delete();
        rhs_log.delete();
        in_log.delete();
    endtask

    logic [15:0] words[$];
    logic [15:0] stream_in[3];
    logic [15:0] stream_lhs[3];
    logic [15:0] stream_rhs[3];

    initial begin
        i_reset     = 1'b1;
        i_valid     = 1'b0;
        i_data      = 16'h0;
        i_lhs_ready = 1'b1;
        i_rhs_ready = 1'b1;
        ref_state   = 32'h0000_0001;
        lhs_last    = 16'h0;
        rhs_last    = 16'h0;
        @(posedge i_clock);
        #1;

        // Reset state
        applyStimulus(1, 0, 16'h0, 1, 1);
        applyStimulus(1, 0, 16'h0, 1, 1);

        // Idle: no handshakes, o_ready held high
        clearLogs();
        for (int c = 0; c < 200; c++) applyStimulus(0, 0, 16'h0, 1, 1);
        check("idle_lhs_hs", lhs_log.size(), 0);
        check("idle_rhs_hs", rhs_log.size(), 0);

        // Streaming example
        stream_in  = '{16'hFFFF, 16'hF0F0, 16'h0F0F};
        stream_lhs = '{16'h0001, 16'h0003, 16'h0002};
        stream_rhs = '{16'hFFFE, 16'hF0F3, 16'h0F0D};
        clearLogs();
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, stream_in[k], 1, 1);
        applyStimulus(0, 0, 16'h0, 1, 1);
        applyStimulus(0, 0, 16'h0, 1, 1);
        check("stream_lhs_hs", lhs_log.size(), 3);
        check("stream_rhs_hs", rhs_log.size(), 3);
        for (int k = 0; k < 3 && k < lhs_log.size() && k < rhs_log.size(); k++) begin
            check("stream_lhs_val", {16'd0, lhs_log[k]}, ZM ? 32'h0 : {16'd0, stream_lhs[k]});
            check("stream_rhs_val", {16'd0, rhs_log[k]},
                  ZM ? {16'd0, stream_in[k]} : {16'd0, stream_rhs[k]});
        end

        // Skewed backpressure
        applyStimulus(1, 0, 16'h0, 1, 1);
        clearLogs();
        applyStimulus(0, 1, 16'h1234, 1, 0);
        for (int c = 0; c < 5; c++) begin
            i_reset = 1'b0; i_valid = 1'b1; i_data = 16'h5678;
            i_lhs_ready = 1'b1; i_rhs_ready = 1'b0;
            #1;
            check("skew_ready_low", {31'd0, o_ready}, 32'd0);
            check("skew_rhs_hold", {16'd0, o_rhs_data}, ZM ? 32'h1234 : 32'h1235);
            #0;
            applyStimulus(0, 1, 16'h5678, 1, 0);
        end
        check("skew_lhs_hs", lhs_log.size(), 1);
        check("skew_rhs_hs", rhs_log.size(), 0);
        applyStimulus(0, 1, 16'h5678, 1, 1);
        applyStimulus(0, 0, 16'h0, 1, 1);
        applyStimulus(0, 0, 16'h0, 1, 1);
        check("skew_lhs_hs2", lhs_log.size(), 2);
        if (lhs_log.size() == 2) begin
            check("skew_next_mask", {16'd0, lhs_log[1]}, ZM ? 32'h0 : 32'h0003);
        end

        // Randomized round trip: shares must recombine to the inputs, in order
        clearLogs();
        words = '{16'hFFFF, 16'hF0F0, 16'h0F0F, 16'h1234, 16'hBEEF, 16'h0000,
                  16'h8001, 16'hA5A5, 16'h5A5A, 16'hCAFE, 16'h7FFE, 16'h1101};
        for (int c = 0; c < 600 && words.size() > 0; c++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), words[0],
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (last_accept) void'(words.pop_front());
        end
        check("rt_all_accepted", words.size(), 0);
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 16'h0, 1, 1);
        check("rt_lhs_count", lhs_log.size(), in_log.size());
        check("rt_rhs_count", rhs_log.size(), in_log.size());
        for (int k = 0; k < in_log.size() && k < lhs_log.size() && k < rhs_log.size(); k++) begin
            check("rt_recombine", {16'd0, lhs_log[k] ^ rhs_log[k]}, {16'd0, in_log[k]});
        end

        // Random traffic with random data
        for (int c = 0; c < 300; c++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-stream with both shares pending
        applyStimulus(0, 1, 16'h4321, 0, 0);
        applyStimulus(0, 1, 16'h4321, 0, 0);
        check("mid_both_valid", {30'd0, o_lhs_valid, o_rhs_valid}, 32'd3);
        applyStimulus(1, 1, 16'h9999, 1, 1);
        check("mid_lhs_cleared", {31'd0, o_lhs_valid}, 32'd0);
        check("mid_rhs_cleared", {31'd0, o_rhs_valid}, 32'd0);
        clearLogs();
        applyStimulus(0, 1, 16'hBEEF, 1, 1);
        applyStimulus(0, 0, 16'h0, 1, 1);
        check("mid_lhs_hs", lhs_log.size(), 1);
        if (lhs_log.size() == 1 && rhs_log.size() == 1) begin
            check("mid_first_mask", {16'd0, lhs_log[0]}, ZM ? 32'h0 : 32'h0001);
            check("mid_first_rhs", {16'd0, rhs_log[0]}, ZM ? 32'hBEEF : 32'hBEEE);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/splitter_gf2.md
Name: splitter_gf2

Overview:
- Inverse of adder_gf2: takes one valid/ready data stream and splits each word into two GF(2) additive shares, lhs and rhs, emitted on two independent valid/ready streams.
- lhs = pseudo-random mask from an internal LFSR; rhs = data XOR mask. Feeding both shares into adder_gf2 reconstructs the original word.
- Sits upstream of adder_gf2 in masking/datapath test chains. It is a 1-to-2 stream fork with registered outputs.

Parameters:
- WIDTH, 16, data width in bits (1..32).
- SEED, 32'h0000_0001, LFSR reset state. A value of 0 is illegal and is replaced by LFSR_DEFAULT_SEED.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_data  in  WIDTH  input word.
- i_valid  in  1  input valid.
- o_ready  out  1  input ready.
- o_lhs_data  out  WIDTH  mask share.
- o_lhs_valid  out  1  lhs valid.
- i_lhs_ready  in  1  lhs downstream ready.
- o_rhs_data  out  WIDTH  masked-data share.
- o_rhs_valid  out  1  rhs valid.
- i_rhs_ready  in  1  rhs downstream ready.

Behaviour:
- Interface clocking: one clock, i_clock; reset i_reset is synchronous, active-high.
- Reset values: o_lhs_valid=0, o_rhs_valid=0, o_lhs_data=0, o_rhs_data=0, LFSR state=SEED. o_ready is 1 combinationally once reset deasserts.
- Slot free conditions:
  - lhs_free = !o_lhs_valid | i_lhs_ready.
  - rhs_free = !o_rhs_valid | i_rhs_ready.
- o_ready = lhs_free & rhs_free. This is combinational from the ready inputs and registered valids; there is no path from i_valid.
- accept = i_valid & o_ready.
- On accept, on the next clock edge:
  - o_lhs_data <= mask.
  - o_rhs_data <= i_data ^ mask.
  - Both valids are set to 1.
  - The LFSR advances one step.
- Latency is 1 cycle. Full-throughput streaming (1 word/cycle) is possible when both readies are held high.
- Independent drain: each output valid clears on its own valid&ready handshake when no new accept occurs that cycle. A share already taken by one consumer is never re-presented.
- Each output's data is held stable while its valid=1 and its ready=0.
- Simultaneous drain and accept in the same cycle: the new accept wins, so the valid stays 1 with new data.
- LFSR:
  - 32-bit Galois, right shift.
  - next = (s>>1) ^ (s[0] ? LFSR_TAPS : 0), with LFSR_TAPS = 32'h8020_0003.
  - mask = s[WIDTH-1:0] of the current (pre-advance) state.
  - The LFSR advances only on accept, never on stall.
- Reset mid-operation: pending shares are discarded (valids go to 0), the LFSR returns to SEED, and no output handshake occurs in the reset cycle.
- No state machine beyond the two valid flags and the LFSR.
- Invariant: for every input word, the XOR of its lhs and rhs shares equals that word.

Optional Feature:
- Macro: SPLITTER_GF2_ZERO_MASK_EN.
- Defined: the LFSR is not instantiated and mask = 0, so o_lhs_data = 0 and o_rhs_data = i_data. Used for debug and for plain-data bring-up; handshake behaviour is unchanged.
- Undefined: the LFSR mask behaves as described above.

Decomposition:
- Package gf2_pkg holds:
  - LFSR_TAPS = 32'h8020_0003.
  - LFSR_DEFAULT_SEED = 32'h0000_0001.
  - typedef lfsr_state_t (logic [31:0]).
  - function lfsr_next(lfsr_state_t).
- One sub-module: lfsr_gf2, with an advance-enable input and state output, reusable by other gf2 blocks.
- The fork logic stays in splitter_gf2.

Test Plan:
- Idle case: i_valid=0 for 200 cycles with both readies high -> zero handshakes on either output, and o_ready=1.
- Streaming case (WIDTH=16, SEED=1, both readies high): inputs 16'hFFFF, 16'hF0F0, 16'h0F0F on consecutive cycles ->
  - lhs outputs are 16'h0001, 16'h0003, 16'h0002.
  - rhs outputs are 16'hFFFE, 16'hF0F3, 16'h0F0D.
  - Each output appears one cycle after its accept; exactly 3 handshakes per side.
- Skewed backpressure: i_rhs_ready=0 for 5 cycles while i_lhs_ready=1, with 16'h1234 offered ->
  - lhs handshakes once.
  - rhs data is held at 16'h1235 and o_ready stays 0 until rhs drains.
  - The LFSR does not advance during the stall; the next word uses mask 16'h0003.
- Round trip: 12 words (16'hFFFF ... 16'h1101) go through splitter_gf2 into adder_gf2 with random readies on both sides -> 12 adder outputs equal the inputs, in order.
- Reset mid-stream: assert i_reset while both valids are 1 -> both valids are 0 next cycle, and the next accepted word gets mask 16'h0001 again.
- With SPLITTER_GF2_ZERO_MASK_EN defined: input 16'hBEEF -> lhs = 16'h0000 and rhs = 16'hBEEF.
